// File: rtl/reg_file_if.sv
// Register file access bundle: two operand read ports, one write-back port,
// one debug read port and the committed-write counter.
// master: datapath/testbench side (drives indices, write data, enable);
// slave: reg_file (drives read data and Write_count).
interface reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] Rs_addr;
    logic [ADDR_W-1:0] Rt_addr;
    logic [ADDR_W-1:0] Rd_addr;
    logic [DATA_W-1:0] Rd_data;
    logic              Reg_write;
    logic [DATA_W-1:0] Rs_data;
    logic [DATA_W-1:0] Rt_data;
    logic [ADDR_W-1:0] Dbg_addr;
    logic [DATA_W-1:0] Dbg_data;
    logic [15:0]       Write_count;

    modport master (
        output Rs_addr,
        output Rt_addr,
        output Rd_addr,
        output Rd_data,
        output Reg_write,
        output Dbg_addr,
        input  Rs_data,
        input  Rt_data,
        input  Dbg_data,
        input  Write_count
    );

    modport slave (
        input  Rs_addr,
        input  Rt_addr,
        input  Rd_addr,
        input  Rd_data,
        input  Reg_write,
        input  Dbg_addr,
        output Rs_data,
        output Rt_data,
        output Dbg_data,
        output Write_count
    );
endinterface

// File: rtl/reg_file.sv
// Architectural general-purpose register file feeding the ALU operands.
// Latency: reads are combinational (zero cycles); writes commit on rising clk.
// Backpressure: none; accepts one write-back every cycle.
//
// Ports:
//   clk  - system clock, writes commit on its rising edge
//   rst  - asynchronous active-high reset; clears all entries and Write_count
//   bus  - reg_file_if.slave: Rs/Rt/Dbg read ports, Rd write port,
//          Reg_write enable, 16-bit Write_count of committed writes
//
// Optional feature macro: REG_FILE_WRITE_BYPASS_EN
//   defined   - a pending write (Reg_write=1, Rd_addr!=0, rst=0) is forwarded
//               combinationally to any read port whose index equals Rd_addr
//   undefined - reads return only the stored value; a write becomes visible
//               in the cycle after the edge that commits it
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    // Entry 0 is hardwired to zero, so no storage is kept for it.
    logic [DATA_W-1:0] r_regs [1:DEPTH-1];
    logic [15:0]       r_write_count;

    // A write commits only to a non-zero index; writes aimed at index 0 are
    // dropped entirely, including the counter increment.
    logic w_commit;
    assign w_commit = bus.Reg_write && (bus.Rd_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_write_count <= '0;
        end else if (w_commit) begin
            r_regs[bus.Rd_addr] <= bus.Rd_data;
            // Natural 16-bit wrap 0xFFFF -> 0x0000.
            r_write_count       <= r_write_count + 16'd1;
        end
    end

    // Stored-value read with index 0 forced to zero.
    function automatic logic [DATA_W-1:0] read_stored(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (a != '0) begin
            v = r_regs[a];
        end
        return v;
    endfunction

    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic [DATA_W-1:0] w_dbg_data;

`ifdef REG_FILE_WRITE_BYPASS_EN
    // Forwarding is held off during reset so every port reads 0 while rst
    // is asserted. Because w_commit already excludes index 0, a match can
    // never make index 0 read non-zero.
    logic w_fwd_en;
    assign w_fwd_en = w_commit && !rst;

    always_comb begin
        w_rs_data  = read_stored(bus.Rs_addr);
        w_rt_data  = read_stored(bus.Rt_addr);
        w_dbg_data = read_stored(bus.Dbg_addr);
        if (w_fwd_en && (bus.Rs_addr == bus.Rd_addr)) begin
            w_rs_data = bus.Rd_data;
        end
        if (w_fwd_en && (bus.Rt_addr == bus.Rd_addr)) begin
            w_rt_data = bus.Rd_data;
        end
        if (w_fwd_en && (bus.Dbg_addr == bus.Rd_addr)) begin
            w_dbg_data = bus.Rd_data;
        end
    end
`else
    always_comb begin
        w_rs_data  = read_stored(bus.Rs_addr);
        w_rt_data  = read_stored(bus.Rt_addr);
        w_dbg_data = read_stored(bus.Dbg_addr);
    end
`endif

    assign bus.Rs_data     = w_rs_data;
    assign bus.Rt_data     = w_rt_data;
    assign bus.Dbg_data    = w_dbg_data;
    assign bus.Write_count = r_write_count;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed test-plan steps followed by
// randomized traffic checked against an array-based reference model.
module tb_reg_file;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 32;

    logic clk;
    logic rst;

    reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: plain array of register contents plus a commit count.
    logic [31:0] model [NREG];
    int unsigned model_count;

`ifdef REG_FILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    function automatic logic [31:0] exp_read(input int a);
        if (a == 0) return 32'h0;
        if (BYPASS && !rst && bus.Reg_write && bus.Rd_addr != 0 && int'(bus.Rd_addr) == a)
            return bus.Rd_data;
        return model[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) model[i] = 32'h0;
        model_count = 0;
    endtask

    // Apply the effect of the coming rising edge to the model.
    task automatic model_edge();
        if (!rst && bus.Reg_write && bus.Rd_addr != 0) begin
            model[bus.Rd_addr] = bus.Rd_data;
            model_count = (model_count + 1) & 32'hFFFF;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if ($isunknown(bus.Reg_write) || $isunknown(bus.Rd_addr))
            $error("illegal stimulus: X on Reg_write/Rd_addr");
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.Reg_write = we;
        bus.Rd_addr   = a;
        bus.Rd_data   = d;
    endtask

    task automatic set_rds(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg);
        bus.Rs_addr  = rs;
        bus.Rt_addr  = rt;
        bus.Dbg_addr = dbg;
    endtask

    initial begin
        rst = 1'b1;
        set_rd(1'b0, 5'd0, 32'h0);
        set_rds(5'd5, 5'd31, 5'd17);
        model_reset();
        @(posedge clk);
        #1;

        // Reset state.
        check("rst_rs", bus.Rs_data, 32'h0);
        check("rst_rt", bus.Rt_data, 32'h0);
        check("rst_dbg", bus.Dbg_data, 32'h0);
        check("rst_count", {16'h0, bus.Write_count}, 32'h0);
        rst = 1'b0;

        // Reset mid-cycle clears a written register at once.
        set_rd(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        set_rd(1'b0, 5'd0, 32'h0);
        set_rds(5'd5, 5'd5, 5'd5);
        #1;
        check("wr_r5", bus.Rs_data, 32'hDEADBEEF);
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_rs", bus.Rs_data, 32'h0);
        check("async_rst_count", {16'h0, bus.Write_count}, 32'h0);
        rst = 1'b0;
        tick();

        // Basic write then read on both operand ports.
        set_rd(1'b1, 5'd8, 32'h00000010);
        tick();
        set_rd(1'b0, 5'd0, 32'h0);
        set_rds(5'd8, 5'd8, 5'd8);
        #1;
        check("wr8_rs", bus.Rs_data, 32'h00000010);
        check("wr8_rt", bus.Rt_data, 32'h00000010);
        check("wr8_count", {16'h0, bus.Write_count}, 32'd1);

        // Write to index 0 is a no-op.
        set_rd(1'b1, 5'd0, 32'hFFFFFFFF);
        set_rds(5'd0, 5'd0, 5'd0);
        #1;
        check("r0_pre_rs", bus.Rs_data, 32'h0);
        tick();
        set_rd(1'b0, 5'd0, 32'h0);
        #1;
        check("r0_rs", bus.Rs_data, 32'h0);
        check("r0_count", {16'h0, bus.Write_count}, 32'd1);

        // Same-cycle read/write of r3.
        set_rd(1'b1, 5'd3, 32'h1);
        tick();
        set_rd(1'b1, 5'd3, 32'h2);
        set_rds(5'd3, 5'd3, 5'd3);
        #1;
        check("rw3_before", bus.Rs_data, BYPASS ? 32'h2 : 32'h1);
        check("rw3_before_model", bus.Rt_data, exp_read(3));
        tick();
        set_rd(1'b0, 5'd0, 32'h0);
        #1;
        check("rw3_after", bus.Rs_data, 32'h2);

        // Enable low for three edges.
        set_rd(1'b0, 5'd9, 32'h12345678);
        set_rds(5'd9, 5'd9, 5'd9);
        for (int i = 0; i < 3; i++) tick();
        check("we0_dbg", bus.Dbg_data, 32'h0);
        check("we0_count", {16'h0, bus.Write_count}, model_count);

        // Randomized traffic against the model.
        for (int it = 0; it < 300; it++) begin
            set_rd(($urandom_range(0, 3) != 0), 5'($urandom_range(0, NREG - 1)), $urandom);
            if ($urandom_range(0, 3) == 0)
                set_rds(bus.Rd_addr, bus.Rd_addr, 5'($urandom_range(0, NREG - 1)));
            else
                set_rds(5'($urandom_range(0, NREG - 1)), 5'($urandom_range(0, NREG - 1)),
                        5'($urandom_range(0, NREG - 1)));
            #1;
            check("rnd_rs", bus.Rs_data, exp_read(int'(bus.Rs_addr)));
            check("rnd_rt", bus.Rt_data, exp_read(int'(bus.Rt_addr)));
            check("rnd_dbg", bus.Dbg_data, exp_read(int'(bus.Dbg_addr)));
            tick();
            check("rnd_count", {16'h0, bus.Write_count}, model_count);
        end

        // Counter wrap: restart from reset, then 65536 writes to r1.
        set_rd(1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        #1;
        model_reset();
        rst = 1'b0;
        tick();
        set_rds(5'd1, 5'd2, 5'd1);
        for (int i = 0; i < 65536; i++) begin
            set_rd(1'b1, 5'd1, 32'(i));
            tick();
            if (i == 65534)
                check("wrap_ffff", {16'h0, bus.Write_count}, 32'h0000FFFF);
        end
        set_rd(1'b0, 5'd0, 32'h0);
        #1;
        check("wrap_count", {16'h0, bus.Write_count}, 32'h0);
        check("wrap_model_count", {16'h0, bus.Write_count}, model_count);
        check("wrap_dbg", bus.Dbg_data, 32'h0000FFFF);
        check("wrap_rt", bus.Rt_data, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
